// File: rtl/reg_list_sequencer.sv
// Steps through an 8-bit register list lowest-set-bit first for LM/SM-class
// instructions, producing register select, one-hot write enable and memory address.
module reg_list_sequencer #(
  parameter int unsigned N_REGS = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_REGS-1:0] reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              advance,
  output logic              busy,
  output logic              valid,
  output logic [IDX_W-1:0]  sel,
  output logic [N_REGS-1:0] wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [IDX_W:0]    count,
  output logic              done,
  output logic              empty_list
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_REGS-1:0]   r_pending;
  logic [N_REGS-1:0]   w_pending_nxt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [IDX_W:0]      r_count;
  logic [IDX_W:0]      w_count_nxt;
  logic                r_empty;
  logic                w_empty_nxt;
  logic [IDX_W-1:0]    w_enc;
  logic [N_REGS-1:0]   w_onehot;
  logic [N_REGS-1:0]   w_remaining;
  logic                w_active;

  // Descending scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    w_enc = '0;
    for (int unsigned i = N_REGS; i > 0; i--) begin
      if (r_pending[i-1]) w_enc = IDX_W'(i - 1);
    end
  end

  assign w_active    = (r_state == S_ACTIVE);
  assign w_onehot    = N_REGS'(1) << w_enc;
  assign w_remaining = r_pending & ~w_onehot;

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_mem_addr_nxt = r_mem_addr;
    w_count_nxt    = r_count;
    w_empty_nxt    = r_empty;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_count_nxt = '0;
          if (reg_list != '0) begin
            w_pending_nxt  = reg_list;
            w_mem_addr_nxt = base_addr;
            w_state_nxt    = S_ACTIVE;
          end else begin
            w_empty_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ACTIVE: begin
        if (advance) begin
          w_pending_nxt  = w_remaining;
          w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
          w_count_nxt    = r_count + (IDX_W+1)'(1);
          if (w_remaining == '0) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_empty_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_pending_nxt = '0;
        w_empty_nxt   = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_mem_addr <= '0;
      r_count    <= '0;
      r_empty    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_count    <= w_count_nxt;
      r_empty    <= w_empty_nxt;
    end
  end

  assign valid      = w_active;
  assign busy       = (r_state == S_ACTIVE) || (r_state == S_DONE);
  assign done       = (r_state == S_DONE);
  assign empty_list = r_empty;
  assign sel        = w_active ? w_enc : '0;
  assign wr_en      = w_active ? w_onehot : '0;
  assign mem_addr   = r_mem_addr;
  assign count      = r_count;

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed self-checking bench for reg_list_sequencer; inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_reg_list_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        advance;
  logic        busy;
  logic        valid;
  logic [2:0]  sel;
  logic [7:0]  wr_en;
  logic [15:0] mem_addr;
  logic [3:0]  count;
  logic        done;
  logic        empty_list;

  int n_checks;
  int n_fail;

  reg_list_sequencer #(
    .N_REGS(8),
    .IDX_W (3),
    .ADDR_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .advance   (advance),
    .busy      (busy),
    .valid     (valid),
    .sel       (sel),
    .wr_en     (wr_en),
    .mem_addr  (mem_addr),
    .count     (count),
    .done      (done),
    .empty_list(empty_list)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {valid, sel, wr_en, mem_addr}
  task automatic test_reset();
    logic [27:0] exp_xfer;
    rst_n = 1'b0; start = 1'b0; reg_list = '0; base_addr = '0; advance = 1'b0;
    #1;
    exp_xfer = {1'b0, 3'd0, 8'h00, 16'h0000};
    n_checks++;
    if ({valid, sel, wr_en, mem_addr} !== exp_xfer) begin
      n_fail++;
      $display("FAIL reset_xfer got=%h want=%h", {valid, sel, wr_en, mem_addr}, exp_xfer);
    end
    n_checks++;
    if ({busy, done, empty_list, count} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_status got=%b want=%b", {busy, done, empty_list, count}, 7'b0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_a5();
    logic [2:0]  exp_sel [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [7:0]  exp_wr  [4] = '{8'h01, 8'h04, 8'h20, 8'h80};
    logic [27:0] exp_xfer;
    start = 1'b1; reg_list = 8'hA5; base_addr = 16'h0100; advance = 1'b1;
    tick();
    start = 1'b0; reg_list = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_xfer = {1'b1, exp_sel[i], exp_wr[i], 16'h0100 + 16'(i)};
      n_checks++;
      if ({valid, sel, wr_en, mem_addr} !== exp_xfer) begin
        n_fail++;
        $display("FAIL a5_step%0d got=%h want=%h", i, {valid, sel, wr_en, mem_addr}, exp_xfer);
      end
      tick();
    end
    n_checks++;
    if ({done, valid, busy, empty_list, count} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd4}) begin
      n_fail++;
      $display("FAIL a5_done got=%b want=%b", {done, valid, busy, empty_list, count}, 8'b1010_0100);
    end
    tick();
    // advance is still high in IDLE and must not disturb anything
    n_checks++;
    if ({done, valid, busy, sel, wr_en, count} !== {3'b000, 3'd0, 8'h00, 4'd4}) begin
      n_fail++;
      $display("FAIL a5_idle got=%h want=%h", {done, valid, busy, sel, wr_en, count}, {3'b000, 3'd0, 8'h00, 4'd4});
    end
  endtask

  task automatic test_empty_list();
    start = 1'b1; reg_list = 8'h00; base_addr = 16'h1234; advance = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({done, empty_list, valid, busy, wr_en, count} !== {4'b1101, 8'h00, 4'd0}) begin
      n_fail++;
      $display("FAIL empty_done got=%h want=%h", {done, empty_list, valid, busy, wr_en, count}, {4'b1101, 8'h00, 4'd0});
    end
    tick();
    n_checks++;
    if ({done, empty_list, valid, busy, count} !== {4'b0000, 4'd0}) begin
      n_fail++;
      $display("FAIL empty_idle got=%b want=%b", {done, empty_list, valid, busy, count}, 8'b0);
    end
  endtask

  task automatic test_full_wrap();
    logic [27:0] exp_xfer;
    start = 1'b1; reg_list = 8'hFF; base_addr = 16'hFFFE; advance = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_xfer = {1'b1, 3'(i), 8'(1 << i), 16'hFFFE + 16'(i)};
      n_checks++;
      if ({valid, sel, wr_en, mem_addr} !== exp_xfer) begin
        n_fail++;
        $display("FAIL ff_step%0d got=%h want=%h", i, {valid, sel, wr_en, mem_addr}, exp_xfer);
      end
      tick();
    end
    n_checks++;
    if ({done, valid, count, mem_addr} !== {2'b10, 4'd8, 16'h0006}) begin
      n_fail++;
      $display("FAIL ff_done got=%h want=%h", {done, valid, count, mem_addr}, {2'b10, 4'd8, 16'h0006});
    end
    tick();
  endtask

  task automatic test_stall();
    logic [27:0] exp_xfer;
    start = 1'b1; reg_list = 8'h12; base_addr = 16'h0040; advance = 1'b0;
    tick();
    start = 1'b0;
    exp_xfer = {1'b1, 3'd1, 8'h02, 16'h0040};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({valid, sel, wr_en, mem_addr} !== exp_xfer) begin
        n_fail++;
        $display("FAIL stall_hold%0d got=%h want=%h", i, {valid, sel, wr_en, mem_addr}, exp_xfer);
      end
      if (i < 2) tick();
    end
    advance = 1'b1;
    tick();
    exp_xfer = {1'b1, 3'd4, 8'h10, 16'h0041};
    n_checks++;
    if ({valid, sel, wr_en, mem_addr} !== exp_xfer) begin
      n_fail++;
      $display("FAIL stall_release got=%h want=%h", {valid, sel, wr_en, mem_addr}, exp_xfer);
    end
    tick();
    n_checks++;
    if ({done, valid, count} !== {2'b10, 4'd2}) begin
      n_fail++;
      $display("FAIL stall_done got=%b want=%b", {done, valid, count}, 6'b10_0010);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    start = 1'b1; reg_list = 8'h0F; base_addr = 16'h0200; advance = 1'b1;
    tick();
    reg_list = 8'h80; base_addr = 16'h0900;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({valid, sel, mem_addr} !== {1'b1, 3'(i), 16'h0200 + 16'(i)}) begin
        n_fail++;
        $display("FAIL ign_step%0d got=%h want=%h", i, {valid, sel, mem_addr}, {1'b1, 3'(i), 16'h0200 + 16'(i)});
      end
      tick();
      start = 1'b0;
    end
    n_checks++;
    if ({done, valid, count} !== {2'b10, 4'd4}) begin
      n_fail++;
      $display("FAIL ign_done got=%b want=%b", {done, valid, count}, 6'b10_0100);
    end
    tick();
  endtask

  task automatic test_reset_midseq();
    start = 1'b1; reg_list = 8'hF0; base_addr = 16'h0300; advance = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    n_checks++;
    if ({valid, sel, count} !== {1'b1, 3'd6, 4'd2}) begin
      n_fail++;
      $display("FAIL rst_pre got=%h want=%h", {valid, sel, count}, {1'b1, 3'd6, 4'd2});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid, busy, done, empty_list, sel, wr_en, mem_addr, count} !== '0) begin
      n_fail++;
      $display("FAIL rst_async got=%h want=0", {valid, busy, done, empty_list, sel, wr_en, mem_addr, count});
    end
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_nodone got=%b want=00", {done, busy});
    end
    rst_n = 1'b1;
    #2;
    start = 1'b1; reg_list = 8'h01; base_addr = 16'h0010;
    tick();
    start = 1'b0;
    n_checks++;
    if ({valid, sel, wr_en, mem_addr} !== {1'b1, 3'd0, 8'h01, 16'h0010}) begin
      n_fail++;
      $display("FAIL rst_restart got=%h want=%h", {valid, sel, wr_en, mem_addr}, {1'b1, 3'd0, 8'h01, 16'h0010});
    end
    tick();
    n_checks++;
    if ({done, count} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL rst_count got=%b want=%b", {done, count}, 5'b1_0001);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_a5();
    test_empty_list();
    test_full_wrap();
    test_stall();
    test_start_ignored();
    test_reset_midseq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
